shift_register_with_valid_ready: RTL and testbench

- Parametrised successor of the valid-only shift register: fixed-depth data delay line with a per-stage valid bit and full valid/ready backpressure.
- Stages advance independently, so empty slots (bubbles) collapse under stall. Also provides synchronous flush and an occupancy count.
- Sits between pipelined arithmetic stages (e.g. formula/isqrt pipes) and consumers that may stall, keeping results aligned with their valid flags.

---
 rtl/shift_register_with_valid_ready.sv | 62 ++++++
 tb/tb_shift_register_with_valid_ready.sv | 224 ++++++++++++++++++++++
 2 files changed

// File: rtl/shift_register_with_valid_ready.sv
// shift_register_with_valid_ready: elastic delay line with per-stage valid, backpressure,
// flush and occupancy count; empty stages collapse while the output is stalled.
module shift_register_with_valid_ready #(
  parameter int width = 8,
  parameter int depth = 8
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         up_vld,
  input  logic [width-1:0]             up_data,
  output logic                         up_rdy,
  output logic                         down_vld,
  output logic [width-1:0]             down_data,
  input  logic                         down_rdy,
  input  logic                         flush,
  output logic [$clog2(depth+1)-1:0]   count
);
  localparam int cw = $clog2(depth+1);
  logic [depth-1:0] vld_q, vld_d, rdy;
  logic [width-1:0] data_q [depth];
  logic [width-1:0] data_d [depth];
  logic [cw-1:0]    count_q, count_d;
  // a stage may load when any stage from it to the output is empty, or the output drains
  for (genvar g = 0; g < depth; g++) begin : g_rdy
    assign rdy[g] = down_rdy | ~&vld_q[depth-1:g];
  end
  assign up_rdy    = rdy[0] & ~flush;
  assign down_vld  = vld_q[depth-1] & ~flush;
  assign down_data = data_q[depth-1];
  assign count     = count_q;
  always_comb begin
    vld_d   = vld_q;
    data_d  = data_q;
    count_d = '0;
    if (up_rdy) begin
      vld_d[0] = up_vld;
      if (up_vld) data_d[0] = up_data;
    end
    for (int i = 1; i < depth; i++)
      if (rdy[i] & ~flush) begin
        vld_d[i] = vld_q[i-1];
        if (vld_q[i-1]) data_d[i] = data_q[i-1];
      end
    if (flush) vld_d = '0;
    for (int i = 0; i < depth; i++) count_d += cw'(vld_d[i]);
  end
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      vld_q   <= '0;
      count_q <= '0;
      for (int i = 0; i < depth; i++) data_q[i] <= '0;
    end else begin
      vld_q   <= vld_d;
      data_q  <= data_d;
      count_q <= count_d;
    end
`ifndef SYNTHESIS
  a_hold: assert property (@(posedge clk) disable iff (rst)
    $past(down_vld & ~down_rdy) |-> down_data == $past(down_data));
  a_count: assert property (@(posedge clk) disable iff (rst) count <= cw'(depth));
`endif
endmodule

// File: tb/tb_shift_register_with_valid_ready.sv
// tb_shift_register_with_valid_ready: scoreboard bench for an 8x8 and a 17x13 instance.
module tb_shift_register_with_valid_ready;
  localparam int WA = 8, DA = 8, WB = 17, DB = 13;
  logic clk = 0, a_rst = 0, b_rst = 0;
  logic a_up_vld = 0, a_up_rdy, a_down_vld, a_down_rdy = 0, a_flush = 0;
  logic [WA-1:0] a_up_data = '0, a_down_data;
  logic [$clog2(DA+1)-1:0] a_count;
  logic b_up_vld = 0, b_up_rdy, b_down_vld, b_down_rdy = 0, b_flush = 0;
  logic [WB-1:0] b_up_data = '0, b_down_data;
  logic [$clog2(DB+1)-1:0] b_count;
  int errs = 0, checks = 0, cyc = 0;
  logic [WA-1:0] qa[$];
  logic [WB-1:0] qb[$];
  int ta[$], tbq[$];
  bit lat_a = 0, lat_b = 0;

  shift_register_with_valid_ready #(.width(WA), .depth(DA)) dut_a (
    .clk(clk), .rst(a_rst), .up_vld(a_up_vld), .up_data(a_up_data), .up_rdy(a_up_rdy),
    .down_vld(a_down_vld), .down_data(a_down_data), .down_rdy(a_down_rdy),
    .flush(a_flush), .count(a_count));
  shift_register_with_valid_ready #(.width(WB), .depth(DB)) dut_b (
    .clk(clk), .rst(b_rst), .up_vld(b_up_vld), .up_data(b_up_data), .up_rdy(b_up_rdy),
    .down_vld(b_down_vld), .down_data(b_down_data), .down_rdy(b_down_rdy),
    .flush(b_flush), .count(b_count));

  always #5 clk = ~clk;
  always @(posedge clk) cyc++;

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errs++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic fail(input string name);
    checks++;
    errs++;
    $display("FAIL %s: output with no expected beat", name);
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  // stimulus side: record every accepted beat and its accept cycle
  always @(negedge clk) begin
    if (!a_rst && a_up_vld && a_up_rdy) begin qa.push_back(a_up_data); ta.push_back(cyc); end
    if (!b_rst && b_up_vld && b_up_rdy) begin qb.push_back(b_up_data); tbq.push_back(cyc); end
  end

  // monitor: compare every downstream transfer against the oldest expected beat
  always @(negedge clk) begin
    if (!a_rst && a_down_vld && a_down_rdy) begin
      if (qa.size() == 0) fail("a_out");
      else begin
        chk("a_data", int'(a_down_data), int'(qa.pop_front()));
        if (lat_a) chk("a_latency", cyc - ta.pop_front(), DA);
        else void'(ta.pop_front());
      end
    end
    if (!b_rst && b_down_vld && b_down_rdy) begin
      if (qb.size() == 0) fail("b_out");
      else begin
        chk("b_data", int'(b_down_data), int'(qb.pop_front()));
        if (lat_b) chk("b_latency", cyc - tbq.pop_front(), DB);
        else void'(tbq.pop_front());
      end
    end
  end

  task automatic drain_a;
    for (int i = 0; i < 40 && !(qa.size() == 0 && !a_down_vld); i++) tick;
    chk("a_drain_left", qa.size(), 0);
  endtask

  task automatic drain_b;
    for (int i = 0; i < 60 && !(qb.size() == 0 && !b_down_vld); i++) tick;
    chk("b_drain_left", qb.size(), 0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    a_rst = 1;
    b_rst = 1;
    #1;
    chk("rst_down_vld", a_down_vld, 0);
    chk("rst_count", a_count, 0);
    chk("rst_up_rdy", a_up_rdy, 1);
    chk("rst_down_data", a_down_data, 0);
    tick;
    tick;
    a_rst = 0;
    b_rst = 0;
    // stream 0x01..0x10 at full rate
    a_down_rdy = 1;
    lat_a = 1;
    for (int k = 1; k <= 16; k++) begin
      a_up_vld = 1; a_up_data = 8'(k);
      #1 chk("t1_up_rdy", a_up_rdy, 1);
      tick;
    end
    a_up_vld = 0;
    drain_a;
    lat_a = 0;
    // stall fill
    a_down_rdy = 0;
    for (int k = 0; k < 10; k++) begin
      a_up_vld = 1; a_up_data = 8'(8'hA0 + k);
      #1 chk("t2_up_rdy", a_up_rdy, int'(k < 8));
      tick;
    end
    a_up_vld = 0;
    #1;
    chk("t2_count", a_count, 8);
    chk("t2_down_vld", a_down_vld, 1);
    chk("t2_down_data", a_down_data, 8'hA0);
    tick;
    chk("t2_held_data", a_down_data, 8'hA0);
    a_down_rdy = 1;
    for (int k = 0; k < 8; k++) begin
      #1 chk("t2_drain_vld", a_down_vld, 1);
      tick;
    end
    #1 chk("t2_empty", a_down_vld, 0);
    // bubble collapse
    a_down_rdy = 0;
    a_up_vld = 1; a_up_data = 8'h11;
    tick;
    a_up_vld = 0;
    repeat (3) tick;
    a_up_vld = 1; a_up_data = 8'h22;
    tick;
    a_up_vld = 0;
    repeat (12) tick;
    #1;
    chk("t3_count", a_count, 2);
    chk("t3_down_vld", a_down_vld, 1);
    chk("t3_down_data", a_down_data, 8'h11);
    a_down_rdy = 1;
    #1 chk("t3_first_vld", a_down_vld, 1);
    tick;
    #1 chk("t3_second_vld", a_down_vld, 1);
    chk("t3_second_data", a_down_data, 8'h22);
    tick;
    #1 chk("t3_empty", a_down_vld, 0);
    // full pipe with simultaneous in/out
    a_down_rdy = 0;
    for (int k = 0; k < 8; k++) begin
      a_up_vld = 1; a_up_data = 8'(8'h30 + k);
      #1 chk("t4_fill_rdy", a_up_rdy, 1);
      tick;
    end
    a_up_vld = 0;
    #1;
    chk("t4_full_count", a_count, 8);
    chk("t4_full_up_rdy", a_up_rdy, 0);
    a_down_rdy = 1; a_up_vld = 1; a_up_data = 8'h5A;
    #1;
    chk("t4_pass_up_rdy", a_up_rdy, 1);
    chk("t4_pass_down_vld", a_down_vld, 1);
    chk("t4_pass_down_data", a_down_data, 8'h30);
    tick;
    a_up_vld = 0; a_down_rdy = 0;
    #1;
    chk("t4_count_after", a_count, 8);
    chk("t4_next_data", a_down_data, 8'h31);
    a_down_rdy = 1;
    drain_a;
    // flush with 5 beats in flight and a beat offered
    for (int k = 0; k < 5; k++) begin
      a_up_vld = 1; a_up_data = 8'(8'h60 + k);
      tick;
    end
    a_flush = 1; a_up_data = 8'h77;
    #1;
    chk("t5_flush_up_rdy", a_up_rdy, 0);
    chk("t5_flush_down_vld", a_down_vld, 0);
    qa.delete();
    ta.delete();
    tick;
    a_flush = 0; a_up_vld = 0;
    #1 chk("t5_count", a_count, 0);
    for (int k = 0; k < 12; k++) begin
      chk("t5_no_output", a_down_vld, 0);
      tick;
    end
    // async reset mid-stream on the 17x13 instance
    b_down_rdy = 1;
    lat_b = 1;
    for (int k = 0; k < 16; k++) begin
      b_up_vld = 1; b_up_data = 17'(k * 4099 + 1);
      tick;
    end
    b_up_vld = 0;
    #1 chk("t6_pre_vld", b_down_vld, 1);
    #1 b_rst = 1;
    #1;
    chk("t6_rst_down_vld", b_down_vld, 0);
    chk("t6_rst_count", b_count, 0);
    chk("t6_rst_up_rdy", b_up_rdy, 1);
    qb.delete();
    tbq.delete();
    tick;
    tick;
    b_rst = 0;
    for (int k = 0; k < 20; k++) begin
      b_up_vld = 1; b_up_data = 17'h1ABCD ^ 17'(k * 257);
      #1 chk("t6_up_rdy", b_up_rdy, 1);
      tick;
    end
    b_up_vld = 0;
    drain_b;
    $display("Result: errors=%0d of %0d checks", errs, checks);
    $finish;
  end
endmodule
